// File: rtl/sump_cmd_parser.sv
// SUMP command receiver: assembles 1-byte short and 5-byte long commands from a byte stream
// and presents them with a single-cycle execute strobe; stale partial long commands time out.
module sump_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH      = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_error,
    output logic [7:0]           opcode,
    output logic [31:0]          config_data,
    output logic                 execute,
    output logic                 cmd_pending,
    output logic                 timeout_err
);

    // state | meaning
    // IDLE  | waiting for an opcode byte
    // ARGS  | long opcode seen, collecting 4 argument bytes LSB first
    typedef enum logic {
        IDLE = 1'b0,
        ARGS = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [1:0]           idx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [7:0]           shadow_op;
    logic [31:0]          shadow_data;
    logic                 accepted;

    assign accepted = rx_valid && !rx_error;
    assign cnt_inc  = cnt + CNT_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 2'd0;
            cnt         <= '0;
            shadow_op   <= 8'h00;
            shadow_data <= 32'h0;
            opcode      <= 8'h00;
            config_data <= 32'h0;
            execute     <= 1'b0;
            cmd_pending <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            execute     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accepted) begin
                        if (!rx_data[7]) begin
                            opcode  <= rx_data;
                            execute <= 1'b1;
                        end else begin
                            shadow_op   <= rx_data;
                            idx         <= 2'd0;
                            cnt         <= '0;
                            state       <= ARGS;
                            cmd_pending <= 1'b1;
                        end
                    end
                end
                ARGS: begin
                    if (rx_valid && rx_error) begin
                        state       <= IDLE;
                        cmd_pending <= 1'b0;
                        timeout_err <= 1'b1;
                        idx         <= 2'd0;
                        cnt         <= '0;
                    end else if (accepted) begin
                        // An arriving byte always beats the terminal count.
                        shadow_data[{idx, 3'b000} +: 8] <= rx_data;
                        idx <= idx + 2'd1;
                        cnt <= '0;
                        if (idx == 2'd3) begin
                            opcode      <= shadow_op;
                            config_data <= {rx_data, shadow_data[23:0]};
                            execute     <= 1'b1;
                            state       <= IDLE;
                            cmd_pending <= 1'b0;
                        end
                    end else if (cnt_inc == CNT_LAST) begin
                        state       <= IDLE;
                        cmd_pending <= 1'b0;
                        timeout_err <= 1'b1;
                        idx         <= 2'd0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sump_cmd_parser.sv
// Directed self-checking bench for sump_cmd_parser with a short inter-byte timeout (16 cycles).
module tb_sump_cmd_parser;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic [7:0]  opcode;
    logic [31:0] config_data;
    logic        execute;
    logic        cmd_pending;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    sump_cmd_parser #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(24)) dut (
        .clock(clock),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_error(rx_error),
        .opcode(opcode),
        .config_data(config_data),
        .execute(execute),
        .cmd_pending(cmd_pending),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic e);
        rx_data  = b;
        rx_valid = v;
        rx_error = e;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        tick(); tick();
        checks += 5;
        if (opcode !== 8'h00) begin errors++; $display("FAIL reset_opcode: got %h want 00", opcode); end
        if (config_data !== 32'h0) begin errors++; $display("FAIL reset_config: got %h want 0", config_data); end
        if (execute !== 1'b0) begin errors++; $display("FAIL reset_execute: got %b want 0", execute); end
        if (cmd_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", cmd_pending); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_short();
        drive(8'h01, 1'b1, 1'b0);
        tick();
        drive(8'h00, 1'b0, 1'b0);
        checks += 4;
        if (execute !== 1'b1) begin errors++; $display("FAIL short_execute: got %b want 1", execute); end
        if (opcode !== 8'h01) begin errors++; $display("FAIL short_opcode: got %h want 01", opcode); end
        if (config_data !== 32'h0) begin errors++; $display("FAIL short_config: got %h want 0", config_data); end
        if (cmd_pending !== 1'b0) begin errors++; $display("FAIL short_pending: got %b want 0", cmd_pending); end
        tick();
        checks++;
        if (execute !== 1'b0) begin errors++; $display("FAIL short_single_pulse: got %b want 0", execute); end
    endtask

    task automatic test_long();
        logic [7:0] bytes [5];
        bytes[0] = 8'hC0; bytes[1] = 8'h78; bytes[2] = 8'h56; bytes[3] = 8'h34; bytes[4] = 8'h12;
        for (int i = 0; i < 5; i++) begin
            drive(bytes[i], 1'b1, 1'b0);
            tick();
            if (i < 4) begin
                checks += 4;
                if (cmd_pending !== 1'b1) begin errors++; $display("FAIL long_pending_%0d: got %b want 1", i, cmd_pending); end
                if (execute !== 1'b0) begin errors++; $display("FAIL long_early_exec_%0d: got %b want 0", i, execute); end
                if (opcode !== 8'h01) begin errors++; $display("FAIL long_opcode_hold_%0d: got %h want 01", i, opcode); end
                if (config_data !== 32'h0) begin errors++; $display("FAIL long_config_hold_%0d: got %h want 0", i, config_data); end
            end
        end
        drive(8'h00, 1'b0, 1'b0);
        checks += 4;
        if (execute !== 1'b1) begin errors++; $display("FAIL long_execute: got %b want 1", execute); end
        if (opcode !== 8'hC0) begin errors++; $display("FAIL long_opcode: got %h want c0", opcode); end
        if (config_data !== 32'h12345678) begin errors++; $display("FAIL long_config: got %h want 12345678", config_data); end
        if (cmd_pending !== 1'b0) begin errors++; $display("FAIL long_pending_end: got %b want 0", cmd_pending); end
        tick();
        checks++;
        if (execute !== 1'b0) begin errors++; $display("FAIL long_single_pulse: got %b want 1->0", execute); end
    endtask

    task automatic test_timeout();
        drive(8'h80, 1'b1, 1'b0); tick();
        drive(8'hAA, 1'b1, 1'b0); tick();
        drive(8'h00, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            checks += 3;
            if (timeout_err !== (k == 16)) begin errors++; $display("FAIL timeout_err_k%0d: got %b want %b", k, timeout_err, (k == 16)); end
            if (execute !== 1'b0) begin errors++; $display("FAIL timeout_no_exec_k%0d: got %b want 0", k, execute); end
            if (cmd_pending !== (k < 16)) begin errors++; $display("FAIL timeout_pending_k%0d: got %b want %b", k, cmd_pending, (k < 16)); end
            tick();
        end
        checks += 2;
        if (opcode !== 8'hC0) begin errors++; $display("FAIL timeout_opcode_hold: got %h want c0", opcode); end
        if (config_data !== 32'h12345678) begin errors++; $display("FAIL timeout_config_hold: got %h want 12345678", config_data); end
        drive(8'h02, 1'b1, 1'b0); tick();
        drive(8'h00, 1'b0, 1'b0);
        checks += 3;
        if (execute !== 1'b1) begin errors++; $display("FAIL after_timeout_exec: got %b want 1", execute); end
        if (opcode !== 8'h02) begin errors++; $display("FAIL after_timeout_opcode: got %h want 02", opcode); end
        if (config_data !== 32'h12345678) begin errors++; $display("FAIL after_timeout_config: got %h want 12345678", config_data); end
        tick();
    endtask

    task automatic test_rx_error();
        drive(8'h81, 1'b1, 1'b0); tick();
        checks++;
        if (cmd_pending !== 1'b1) begin errors++; $display("FAIL rxerr_pending: got %b want 1", cmd_pending); end
        drive(8'h11, 1'b1, 1'b1); tick();
        checks += 3;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL rxerr_abort: got %b want 1", timeout_err); end
        if (execute !== 1'b0) begin errors++; $display("FAIL rxerr_no_exec: got %b want 0", execute); end
        if (cmd_pending !== 1'b0) begin errors++; $display("FAIL rxerr_pending_clr: got %b want 0", cmd_pending); end
        drive(8'h00, 1'b1, 1'b0); tick();
        drive(8'h00, 1'b0, 1'b0);
        checks += 4;
        if (execute !== 1'b1) begin errors++; $display("FAIL rxerr_next_exec: got %b want 1", execute); end
        if (opcode !== 8'h00) begin errors++; $display("FAIL rxerr_next_opcode: got %h want 00", opcode); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL rxerr_single_pulse: got %b want 0", timeout_err); end
        if (config_data !== 32'h12345678) begin errors++; $display("FAIL rxerr_config_hold: got %h want 12345678", config_data); end
        // An errored byte in IDLE must be ignored entirely.
        drive(8'h05, 1'b1, 1'b1); tick();
        drive(8'h00, 1'b0, 1'b0);
        checks += 3;
        if (execute !== 1'b0) begin errors++; $display("FAIL idle_err_exec: got %b want 0", execute); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL idle_err_timeout: got %b want 0", timeout_err); end
        if (opcode !== 8'h00) begin errors++; $display("FAIL idle_err_opcode: got %h want 00", opcode); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes [3];
        bytes[0] = 8'h82; bytes[1] = 8'h01; bytes[2] = 8'h02;
        for (int i = 0; i < 3; i++) begin
            drive(bytes[i], 1'b1, 1'b0); tick();
        end
        drive(8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 5;
        if (execute !== 1'b0) begin errors++; $display("FAIL rstmid_exec: got %b want 0", execute); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: got %b want 0", timeout_err); end
        if (cmd_pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b want 0", cmd_pending); end
        if (opcode !== 8'h00) begin errors++; $display("FAIL rstmid_opcode: got %h want 00", opcode); end
        if (config_data !== 32'h0) begin errors++; $display("FAIL rstmid_config: got %h want 0", config_data); end
        drive(8'h03, 1'b1, 1'b0); tick();
        drive(8'h00, 1'b0, 1'b0);
        checks += 3;
        if (execute !== 1'b1) begin errors++; $display("FAIL rstmid_next_exec: got %b want 1", execute); end
        if (opcode !== 8'h03) begin errors++; $display("FAIL rstmid_next_opcode: got %h want 03", opcode); end
        if (config_data !== 32'h0) begin errors++; $display("FAIL rstmid_next_config: got %h want 0", config_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        bytes[0] = 8'h00; bytes[1] = 8'h00; bytes[2] = 8'h00;
        bytes[3] = 8'h00; bytes[4] = 8'h00; bytes[5] = 8'h11;
        for (int i = 0; i < 6; i++) begin
            drive(bytes[i], 1'b1, 1'b0); tick();
            checks += 2;
            if (execute !== 1'b1) begin errors++; $display("FAIL b2b_exec_%0d: got %b want 1", i, execute); end
            if (opcode !== bytes[i]) begin errors++; $display("FAIL b2b_opcode_%0d: got %h want %h", i, opcode, bytes[i]); end
        end
        drive(8'h00, 1'b0, 1'b0); tick();
        checks++;
        if (execute !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", execute); end
    endtask

    task automatic test_terminal_boundary();
        drive(8'h83, 1'b1, 1'b0); tick();
        drive(8'h00, 1'b0, 1'b0);
        // Idle up to the last cycle before the abort would fire, then deliver a byte there.
        for (int k = 1; k < 15; k++) tick();
        drive(8'hEF, 1'b1, 1'b0); tick();
        drive(8'h00, 1'b0, 1'b0);
        checks += 2;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL tc_byte_wins_err: got %b want 0", timeout_err); end
        if (cmd_pending !== 1'b1) begin errors++; $display("FAIL tc_byte_wins_pending: got %b want 1", cmd_pending); end
        // Counter restarted: 14 more idle cycles must not abort either.
        for (int k = 1; k < 15; k++) begin
            checks++;
            if (timeout_err !== 1'b0) begin errors++; $display("FAIL tc_restart_k%0d: got %b want 0", k, timeout_err); end
            tick();
        end
        drive(8'hBE, 1'b1, 1'b0); tick();
        drive(8'hAD, 1'b1, 1'b0); tick();
        drive(8'hDE, 1'b1, 1'b0); tick();
        drive(8'h00, 1'b0, 1'b0);
        checks += 3;
        if (execute !== 1'b1) begin errors++; $display("FAIL tc_exec: got %b want 1", execute); end
        if (opcode !== 8'h83) begin errors++; $display("FAIL tc_opcode: got %h want 83", opcode); end
        if (config_data !== 32'hDEADBEEF) begin errors++; $display("FAIL tc_config: got %h want deadbeef", config_data); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        test_reset();
        test_short();
        test_long();
        test_timeout();
        test_rx_error();
        test_reset_mid();
        test_back_to_back();
        test_terminal_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
